seg_scan_mux: RTL

- Parametrised multiplexed seven-segment scanner. It succeeds the fixed 8-digit scanner used by the stopwatch display path.
- Drives NUM_DIGITS common-select lines one at a time, with a per-slot dead time, brightness PWM, per-digit decimal points and blanking.
- Latches the display word once per frame, so a counter changing mid-scan never tears a frame.
- Sits between the stopwatch/timer datapath and the board's segment/select pins.

---
 rtl/seg_pkg.sv | 18 +
 rtl/seg7_decode.sv | 13 +
 rtl/seg_scan_mux.sv | 118 +++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment encoding: hex-to-segment table, blank/dash patterns and decode helper.
// Segment bit order is {dp, g, f, e, d, c, b, a}, active-high.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DASH  = 8'h40;

  // Index 15 ('F') renders a dash: the display path's "no value" marker.
  localparam logic [15:0][7:0] SEG_TABLE = {
    SEG_DASH, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07,    8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  function automatic logic [7:0] seg_decode(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble + decimal point to 8-bit segment pattern.
// Reusable by any display that follows the seg_pkg encoding.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = seg_decode(nibble) | {dp, 7'b0};

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment scanner: per-slot dead time, brightness PWM, per-frame shadowing.
// Define SEG_SCAN_LZS_EN to enable leading-zero suppression at shadow load.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned SCAN_DIV    = 100_000,
  parameter int unsigned DEAD_CYCLES = 1000,
  parameter int unsigned BRIGHT_W    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [7:0]              seg_data,
  output logic [NUM_DIGITS-1:0]   seg_cs,
  output logic                    frame_start
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int LW    = CNT_W + 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int STEP  = (SCAN_DIV - DEAD_CYCLES) >> BRIGHT_W;

  logic [CNT_W-1:0]                slot_cnt;
  logic [IDX_W-1:0]                digit_idx;
  logic [NUM_DIGITS-1:0][3:0]      shadow_data;
  logic [NUM_DIGITS-1:0]           shadow_dp;
  logic [NUM_DIGITS-1:0]           shadow_blank;
  logic [NUM_DIGITS-1:0]           blank_eff;
  logic                            slot_end;
  logic                            last_digit;
  logic                            frame_end;
  logic [LW-1:0]                   on_len;
  logic                            lit;
  logic                            show;
  logic [7:0]                      dec_seg;

  assign slot_end   = (slot_cnt == CNT_W'(SCAN_DIV - 1));
  assign last_digit = (digit_idx == IDX_W'(NUM_DIGITS - 1));
  assign frame_end  = slot_end && last_digit;

  // Brightness is live, not shadowed, so dimming takes effect mid-frame.
  assign on_len = (&brightness) ? LW'(SCAN_DIV - DEAD_CYCLES)
                                : LW'(brightness) * LW'(STEP);
  assign lit    = (slot_cnt >= CNT_W'(DEAD_CYCLES)) &&
                  ({1'b0, slot_cnt} < (LW'(DEAD_CYCLES) + on_len));
  assign show   = lit && !blank_eff[digit_idx];

  seg7_decode u_dec (
    .nibble (shadow_data[digit_idx]),
    .dp     (shadow_dp[digit_idx]),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt     <= '0;
      digit_idx    <= '0;
      shadow_data  <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      frame_start  <= 1'b0;
      seg_cs       <= '0;
      seg_data     <= SEG_BLANK;
    end else begin
      if (slot_end) begin
        slot_cnt  <= '0;
        digit_idx <= last_digit ? '0 : digit_idx + IDX_W'(1);
      end else begin
        slot_cnt  <= slot_cnt + CNT_W'(1);
      end
      // The shadow swaps on the final edge of a frame so slot 0 of digit 0 sees the new word.
      if (frame_end) begin
        shadow_data  <= data;
        shadow_dp    <= dp;
        shadow_blank <= blank_mask;
      end
      frame_start <= frame_end;
      seg_cs      <= show ? (NUM_DIGITS'(1) << digit_idx) : '0;
      seg_data    <= show ? dec_seg : SEG_BLANK;
    end
  end

`ifdef SEG_SCAN_LZS_EN
  logic [NUM_DIGITS-1:0] lzs_next;
  logic [NUM_DIGITS-1:0] lzs_mask;

  // Walk down from the top digit; the first nonzero nibble or set dp ends suppression.
  always_comb begin
    logic keep;
    lzs_next = '0;
    keep     = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      if (keep && (data[4*k +: 4] == 4'h0) && !dp[k]) begin
        lzs_next[k] = 1'b1;
      end else begin
        keep = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lzs_mask <= '0;
    end else if (frame_end) begin
      lzs_mask <= lzs_next;
    end
  end

  assign blank_eff = shadow_blank | lzs_mask;
`else
  assign blank_eff = shadow_blank;
`endif

endmodule
